model_trainer_fnn_sequencer: RTL and testbench
==============================================

MODEL_TRAINER_FNN_SEQUENCER -- requirements
Module: model_trainer_fnn_sequencer

Interface
REQ-001 Parameter DATA_SIZE, default 64, SHALL set the width of every data and size port.
REQ-002 Parameter WATCHDOG_CYCLES, default 1024, SHALL set the READY timeout in cycles when the timeout feature is compiled in.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 RST  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 CMD_START in 1 starts a run; CMD_BUSY out 1 is high while a run is in progress; CMD_DONE out 1 is a one-cycle completion pulse.
REQ-006 SIZE_X_IN, SIZE_L_IN  in  DATA_SIZE  SHALL give the input-vector length X and layer length L, sampled on an accepted CMD_START.
REQ-007 SRC_VALID in 1, SRC_READY out 1, SRC_DATA in DATA_SIZE SHALL form the operand stream: W row-major, then B, then X.
REQ-008 TRAINER_START out 1, TRAINER_READY in 1 SHALL connect to the FNN trainer control pair.
REQ-009 W_IN_L_ENABLE, W_IN_X_ENABLE, B_IN_ENABLE, X_IN_ENABLE  out  1 each SHALL qualify trainer operand beats.
REQ-010 W_IN, B_IN, X_IN  out  DATA_SIZE  SHALL carry trainer operand data.
REQ-011 H_OUT_ENABLE in 1, H_OUT in DATA_SIZE SHALL be the trainer result stream.
REQ-012 SNK_VALID out 1, SNK_DATA out DATA_SIZE SHALL forward results; the sink SHALL always accept.
REQ-013 SIZE_ERR out 1 and TIMEOUT_ERR out 1 SHALL be sticky status flags, cleared on the next accepted CMD_START.

Function
REQ-014 FSM states SHALL be IDLE, LOAD_W, LOAD_B, LOAD_X, START, WAIT, DONE.
REQ-015 IDLE: CMD_START=1 SHALL latch sizes, clear flags and enter LOAD_W next cycle; CMD_START in any other state SHALL be ignored.
REQ-016 If latched X=0 or L=0, the FSM SHALL go IDLE->DONE, set SIZE_ERR, and never assert TRAINER_START.
REQ-017 SRC_READY SHALL be 1 only in LOAD_W/LOAD_B/LOAD_X; a beat transfers when SRC_VALID&&SRC_READY.
REQ-018 Each transferred beat SHALL be registered onto the matching *_IN data and enable outputs exactly one cycle later, enables high for one cycle per beat.
REQ-019 LOAD_W: row counter i (0..L-1), column counter j (0..X-1); every beat asserts W_IN_X_ENABLE; W_IN_L_ENABLE additionally when j=0; j wraps to 0 and i increments after j=X-1; after beat (L-1,X-1) go LOAD_B.
REQ-020 LOAD_B SHALL take exactly L beats with B_IN_ENABLE; LOAD_X exactly X beats with X_IN_ENABLE; then START.
REQ-021 SRC_VALID low SHALL stall counters with no enable asserted; no beat lost or duplicated.
REQ-022 START SHALL assert TRAINER_START for exactly one cycle, after the last operand enable has been driven, then enter WAIT.
REQ-023 In WAIT, each H_OUT_ENABLE SHALL produce SNK_VALID=1 with SNK_DATA=H_OUT one cycle later; TRAINER_READY=1 SHALL go DONE; H_OUT_ENABLE and TRAINER_READY in the same cycle SHALL still forward that beat.
REQ-024 DONE SHALL assert CMD_DONE for one cycle and return to IDLE; CMD_BUSY SHALL be 1 in every state except IDLE.
REQ-025 Counters SHALL be DATA_SIZE wide, unsigned, with no overflow beyond the latched size.

Reset
REQ-026 RST=0 SHALL immediately force IDLE, zero all counters, and drive every output (including flags, data and enables) to 0, also mid-run.
REQ-027 After RST release the block SHALL accept CMD_START on the first clock edge.

Configuration
REQ-028 Macro TRAINER_FNN_SEQUENCER_TIMEOUT_EN defined: WAIT counts cycles; reaching WATCHDOG_CYCLES without TRAINER_READY SHALL set TIMEOUT_ERR and go DONE.
REQ-029 Macro undefined: WAIT lasts indefinitely, no watchdog counter exists, TIMEOUT_ERR tied to 0.

Verification
REQ-030 X=2, L=3, 11 beats 1..11 with SRC_VALID constant -> W_IN 1..6 with W_IN_L_ENABLE on 1,3,5; B_IN 7..9; X_IN 10,11; one TRAINER_START.
REQ-031 Same run, SRC_VALID toggled every other cycle -> identical enable/data sequence, TRAINER_START still once.
REQ-032 WAIT, H_OUT_ENABLE with H_OUT=0xA5 in same cycle as TRAINER_READY -> SNK_VALID with 0xA5 next cycle, CMD_DONE following cycle.
REQ-033 SIZE_X_IN=0, CMD_START -> SIZE_ERR=1, CMD_DONE pulse, TRAINER_START never asserted, SRC_READY stays 0.
REQ-034 RST=0 during LOAD_B -> all outputs 0 asynchronously; new run after release completes normally.
REQ-035 TIMEOUT_EN defined, WATCHDOG_CYCLES=16, TRAINER_READY held 0 -> TIMEOUT_ERR=1 and CMD_DONE 16 cycles after TRAINER_START.

Source files
------------

// File: rtl/model_trainer_fnn_sequencer_if.sv
// Bundle of every non-clock signal of model_trainer_fnn_sequencer.
//   master : the sequencer side (drives command status, operand stream
//            to the trainer, SRC_READY, sink stream and error flags)
//   slave  : the environment side (command, source stream, trainer
//            handshake and trainer result stream)
// Handshake rule: a source beat transfers on a rising CLK edge where
// SRC_VALID and SRC_READY are both 1; the sink never back-pressures, so
// SNK_VALID alone marks a result beat.
interface model_trainer_fnn_sequencer_if #(
    parameter int DATA_SIZE = 64
);
    logic                 CMD_START;
    logic                 CMD_BUSY;
    logic                 CMD_DONE;
    logic [DATA_SIZE-1:0] SIZE_X_IN;
    logic [DATA_SIZE-1:0] SIZE_L_IN;
    logic                 SRC_VALID;
    logic                 SRC_READY;
    logic [DATA_SIZE-1:0] SRC_DATA;
    logic                 TRAINER_START;
    logic                 TRAINER_READY;
    logic                 W_IN_L_ENABLE;
    logic                 W_IN_X_ENABLE;
    logic                 B_IN_ENABLE;
    logic                 X_IN_ENABLE;
    logic [DATA_SIZE-1:0] W_IN;
    logic [DATA_SIZE-1:0] B_IN;
    logic [DATA_SIZE-1:0] X_IN;
    logic                 H_OUT_ENABLE;
    logic [DATA_SIZE-1:0] H_OUT;
    logic                 SNK_VALID;
    logic [DATA_SIZE-1:0] SNK_DATA;
    logic                 SIZE_ERR;
    logic                 TIMEOUT_ERR;

    modport master (
        input  CMD_START, SIZE_X_IN, SIZE_L_IN, SRC_VALID, SRC_DATA,
               TRAINER_READY, H_OUT_ENABLE, H_OUT,
        output CMD_BUSY, CMD_DONE, SRC_READY, TRAINER_START,
               W_IN_L_ENABLE, W_IN_X_ENABLE, B_IN_ENABLE, X_IN_ENABLE,
               W_IN, B_IN, X_IN, SNK_VALID, SNK_DATA, SIZE_ERR, TIMEOUT_ERR
    );

    modport slave (
        output CMD_START, SIZE_X_IN, SIZE_L_IN, SRC_VALID, SRC_DATA,
               TRAINER_READY, H_OUT_ENABLE, H_OUT,
        input  CMD_BUSY, CMD_DONE, SRC_READY, TRAINER_START,
               W_IN_L_ENABLE, W_IN_X_ENABLE, B_IN_ENABLE, X_IN_ENABLE,
               W_IN, B_IN, X_IN, SNK_VALID, SNK_DATA, SIZE_ERR, TIMEOUT_ERR
    );
endinterface

// File: rtl/model_trainer_fnn_sequencer.sv
// Sequencer in front of an FNN trainer. On CMD_START it latches the input
// length X and layer length L, pulls W (L rows of X, row-major), then B
// (L beats), then X (X beats) from the source stream and replays each beat
// one cycle later on the trainer operand ports. It then pulses
// TRAINER_START, forwards trainer results to the sink until TRAINER_READY
// and finishes with a one-cycle CMD_DONE.
// Ports:
//   CLK, RST   : clock, asynchronous active-low reset
//   state_dbg  : current FSM state (debug)
//   bus        : model_trainer_fnn_sequencer_if.master (all other signals)
// Optional feature: define TRAINER_FNN_SEQUENCER_TIMEOUT_EN to add a
// WATCHDOG_CYCLES watchdog in WAIT that raises TIMEOUT_ERR.
module model_trainer_fnn_sequencer #(
    parameter int DATA_SIZE       = 64,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [2:0] state_dbg,
    model_trainer_fnn_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_LOAD_X = 3'd3;
    localparam logic [2:0] S_START  = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [DATA_SIZE-1:0] ZERO = '0;
    localparam logic [DATA_SIZE-1:0] ONE  = {{(DATA_SIZE-1){1'b0}}, 1'b1};

    // The watchdog fires one cycle early because CMD_DONE is registered
    // out of DONE; this keeps CMD_DONE exactly WATCHDOG_CYCLES after
    // TRAINER_START, and needs at least two cycles to work.
    if (WATCHDOG_CYCLES < 2) begin : g_bad_watchdog
        $error("WATCHDOG_CYCLES must be at least 2");
    end

    logic [2:0]           state_q, state_d;
    logic [DATA_SIZE-1:0] i_q, i_d;   // W row / B beat counter
    logic [DATA_SIZE-1:0] j_q, j_d;   // W column / X beat counter
    logic [DATA_SIZE-1:0] x_q, x_d;
    logic [DATA_SIZE-1:0] l_q, l_d;
    logic [DATA_SIZE-1:0] w_in_q, w_in_d, b_in_q, b_in_d, x_in_q, x_in_d;
    logic [DATA_SIZE-1:0] snk_data_q, snk_data_d;
    logic w_l_en_q, w_l_en_d, w_x_en_q, w_x_en_d;
    logic b_en_q, b_en_d, x_en_q, x_en_d;
    logic trainer_start_q, trainer_start_d;
    logic snk_valid_q, snk_valid_d;
    logic cmd_done_q, cmd_done_d;
    logic size_err_q, size_err_d;
    logic src_ready, beat;

`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
    localparam int WDOG_W = $clog2(WATCHDOG_CYCLES) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WATCHDOG_CYCLES - 2);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic timeout_err_q, timeout_err_d;
`endif

    assign src_ready = (state_q == S_LOAD_W) || (state_q == S_LOAD_B) ||
                       (state_q == S_LOAD_X);
    assign beat      = src_ready && bus.SRC_VALID;

    always_comb begin
        state_d         = state_q;
        i_d             = i_q;
        j_d             = j_q;
        x_d             = x_q;
        l_d             = l_q;
        w_in_d          = w_in_q;
        b_in_d          = b_in_q;
        x_in_d          = x_in_q;
        snk_data_d      = snk_data_q;
        w_l_en_d        = 1'b0;
        w_x_en_d        = 1'b0;
        b_en_d          = 1'b0;
        x_en_d          = 1'b0;
        trainer_start_d = 1'b0;
        snk_valid_d     = 1'b0;
        cmd_done_d      = 1'b0;
        size_err_d      = size_err_q;
`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
        wdog_d          = wdog_q;
        timeout_err_d   = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.CMD_START) begin
                    x_d        = bus.SIZE_X_IN;
                    l_d        = bus.SIZE_L_IN;
                    i_d        = ZERO;
                    j_d        = ZERO;
                    size_err_d = 1'b0;
`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                    if (bus.SIZE_X_IN == ZERO || bus.SIZE_L_IN == ZERO) begin
                        size_err_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d    = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                if (beat) begin
                    w_in_d   = bus.SRC_DATA;
                    w_x_en_d = 1'b1;
                    w_l_en_d = (j_q == ZERO);   // first column opens a row
                    if (j_q == x_q - ONE) begin
                        j_d = ZERO;
                        if (i_q == l_q - ONE) begin
                            i_d     = ZERO;
                            state_d = S_LOAD_B;
                        end else begin
                            i_d = i_q + ONE;
                        end
                    end else begin
                        j_d = j_q + ONE;
                    end
                end
            end
            S_LOAD_B: begin
                if (beat) begin
                    b_in_d = bus.SRC_DATA;
                    b_en_d = 1'b1;
                    if (i_q == l_q - ONE) begin
                        i_d     = ZERO;
                        state_d = S_LOAD_X;
                    end else begin
                        i_d = i_q + ONE;
                    end
                end
            end
            S_LOAD_X: begin
                if (beat) begin
                    x_in_d = bus.SRC_DATA;
                    x_en_d = 1'b1;
                    if (j_q == x_q - ONE) begin
                        j_d     = ZERO;
                        state_d = S_START;
                    end else begin
                        j_d = j_q + ONE;
                    end
                end
            end
            S_START: begin
                // Registered, so it lands one cycle after the last X_IN_ENABLE.
                trainer_start_d = 1'b1;
                state_d         = S_WAIT;
`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
                wdog_d          = '0;
`endif
            end
            S_WAIT: begin
                if (bus.H_OUT_ENABLE) begin
                    snk_valid_d = 1'b1;
                    snk_data_d  = bus.H_OUT;
                end
                if (bus.TRAINER_READY) begin
                    state_d = S_DONE;
                end
`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                cmd_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= S_IDLE;
            i_q             <= '0;
            j_q             <= '0;
            x_q             <= '0;
            l_q             <= '0;
            w_in_q          <= '0;
            b_in_q          <= '0;
            x_in_q          <= '0;
            snk_data_q      <= '0;
            w_l_en_q        <= 1'b0;
            w_x_en_q        <= 1'b0;
            b_en_q          <= 1'b0;
            x_en_q          <= 1'b0;
            trainer_start_q <= 1'b0;
            snk_valid_q     <= 1'b0;
            cmd_done_q      <= 1'b0;
            size_err_q      <= 1'b0;
`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
            wdog_q          <= '0;
            timeout_err_q   <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            i_q             <= i_d;
            j_q             <= j_d;
            x_q             <= x_d;
            l_q             <= l_d;
            w_in_q          <= w_in_d;
            b_in_q          <= b_in_d;
            x_in_q          <= x_in_d;
            snk_data_q      <= snk_data_d;
            w_l_en_q        <= w_l_en_d;
            w_x_en_q        <= w_x_en_d;
            b_en_q          <= b_en_d;
            x_en_q          <= x_en_d;
            trainer_start_q <= trainer_start_d;
            snk_valid_q     <= snk_valid_d;
            cmd_done_q      <= cmd_done_d;
            size_err_q      <= size_err_d;
`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
            wdog_q          <= wdog_d;
            timeout_err_q   <= timeout_err_d;
`endif
        end
    end

    assign state_dbg         = state_q;
    assign bus.CMD_BUSY      = (state_q != S_IDLE);
    assign bus.CMD_DONE      = cmd_done_q;
    assign bus.SRC_READY     = src_ready;
    assign bus.TRAINER_START = trainer_start_q;
    assign bus.W_IN_L_ENABLE = w_l_en_q;
    assign bus.W_IN_X_ENABLE = w_x_en_q;
    assign bus.B_IN_ENABLE   = b_en_q;
    assign bus.X_IN_ENABLE   = x_en_q;
    assign bus.W_IN          = w_in_q;
    assign bus.B_IN          = b_in_q;
    assign bus.X_IN          = x_in_q;
    assign bus.SNK_VALID     = snk_valid_q;
    assign bus.SNK_DATA      = snk_data_q;
    assign bus.SIZE_ERR      = size_err_q;
`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
    assign bus.TIMEOUT_ERR   = timeout_err_q;
`else
    assign bus.TIMEOUT_ERR   = 1'b0;
`endif
endmodule

// File: tb/tb_model_trainer_fnn_sequencer.sv
// Testbench for model_trainer_fnn_sequencer. Operand traffic is predicted
// from the sizes and the source word list (W row-major with a row marker on
// each first column, then B, then X); sink traffic from the words the bench
// feeds as trainer results.
module tb_model_trainer_fnn_sequencer;
    localparam int DW = 16;
    localparam int WD = 16;
    localparam int EW = 4 + DW;   // {w_l, w_x, b, x, data}

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] state_dbg;

    model_trainer_fnn_sequencer_if #(.DATA_SIZE(DW)) bus();

    model_trainer_fnn_sequencer #(.DATA_SIZE(DW), .WATCHDOG_CYCLES(WD)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .state_dbg (state_dbg),
        .bus       (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] act_q[$];
    logic [DW-1:0] exp_snk_q[$];
    logic [DW-1:0] act_snk_q[$];
    logic [DW-1:0] src_mem[$];
    int cyc = 0, ts_cnt = 0, ts_cyc = -1, last_en_cyc = -1, done_cnt = 0;

    logic [11+4*DW-1:0] outs;
    assign outs = {bus.CMD_BUSY, bus.CMD_DONE, bus.SRC_READY, bus.TRAINER_START,
                   bus.W_IN_L_ENABLE, bus.W_IN_X_ENABLE, bus.B_IN_ENABLE,
                   bus.X_IN_ENABLE, bus.SNK_VALID, bus.SIZE_ERR, bus.TIMEOUT_ERR,
                   bus.W_IN, bus.B_IN, bus.X_IN, bus.SNK_DATA};

    always @(negedge CLK) begin
        logic [DW-1:0] d;
        cyc++;
        if (bus.W_IN_L_ENABLE || bus.W_IN_X_ENABLE || bus.B_IN_ENABLE || bus.X_IN_ENABLE) begin
            d = (bus.W_IN_L_ENABLE || bus.W_IN_X_ENABLE) ? bus.W_IN :
                (bus.B_IN_ENABLE ? bus.B_IN : bus.X_IN);
            act_q.push_back({bus.W_IN_L_ENABLE, bus.W_IN_X_ENABLE, bus.B_IN_ENABLE,
                             bus.X_IN_ENABLE, d});
            last_en_cyc = cyc;
        end
        if (bus.TRAINER_START) begin
            ts_cnt++;
            ts_cyc = cyc;
        end
        if (bus.SNK_VALID) act_snk_q.push_back(bus.SNK_DATA);
        if (bus.CMD_DONE) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.CMD_START     = 1'b0;
        bus.SIZE_X_IN     = '0;
        bus.SIZE_L_IN     = '0;
        bus.SRC_VALID     = 1'b0;
        bus.SRC_DATA      = '0;
        bus.TRAINER_READY = 1'b0;
        bus.H_OUT_ENABLE  = 1'b0;
        bus.H_OUT         = '0;
    endtask

    task automatic clear_monitor();
        @(posedge CLK);
        #1;
        act_q.delete();
        act_snk_q.delete();
        exp_q.delete();
        exp_snk_q.delete();
        ts_cnt = 0;
        ts_cyc = -1;
        last_en_cyc = -1;
        done_cnt = 0;
    endtask

    task automatic pulse_start(input int x, input int l);
        @(negedge CLK);
        bus.CMD_START = 1'b1;
        bus.SIZE_X_IN = DW'(x);
        bus.SIZE_L_IN = DW'(l);
        @(negedge CLK);
        bus.CMD_START = 1'b0;
    endtask

    // Feeds src_mem[0..n_beats-1]; mode 0 = always valid, 1 = every other
    // cycle, 2 = random gaps. poke re-issues an illegal CMD_START mid-load.
    task automatic drive_src(input int n_beats, input int mode, input bit poke);
        int idx = 0;
        int c = 0;
        logic v, rdy;
        while (idx < n_beats && c < 4000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0);
            if (poke && c == 2) begin
                bus.CMD_START = 1'b1;
                bus.SIZE_X_IN = '0;
            end
            if (poke && c == 4) bus.CMD_START = 1'b0;
            bus.SRC_VALID = v;
            bus.SRC_DATA  = v ? src_mem[idx] : DW'($urandom);
            rdy = bus.SRC_READY;
            @(negedge CLK);
            if (v && rdy) idx++;
            c++;
        end
        bus.SRC_VALID = 1'b0;
        bus.CMD_START = 1'b0;
        n_checks++;
        if (idx !== n_beats) begin
            n_fail++;
            $display("FAIL src_transfer: %0d beats accepted, required %0d", idx, n_beats);
        end
    endtask

    task automatic build_expected(input int x, input int l);
        for (int k = 0; k < l * x; k++)
            exp_q.push_back({(k % x == 0), 1'b1, 2'b00, src_mem[k]});
        for (int k = 0; k < l; k++)
            exp_q.push_back({4'b0010, src_mem[l * x + k]});
        for (int k = 0; k < x; k++)
            exp_q.push_back({4'b0001, src_mem[l * x + l + k]});
    endtask

    task automatic wait_trainer_start(input string name, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (bus.TRAINER_START) seen = 1'b1;
            else @(negedge CLK);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_trainer_start: not seen within 20 cycles, required a pulse", name);
        end
    endtask

    task automatic wait_cmd_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (bus.CMD_DONE) seen = 1'b1;
            else @(negedge CLK);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_cmd_done: not seen within 20 cycles, required a pulse", name);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (outs !== '0 || state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: outs=%h state=%0d, required all 0", outs, state_dbg);
        end
        RST = 1'b1;
    endtask

    task automatic run_and_check(input string name, input int x, input int l,
                                 input int mode, input bit fixed, input bit a5);
        int n;
        bit seen;
        clear_monitor();
        n = l * x + l + x;
        src_mem.delete();
        for (int k = 0; k < n; k++) src_mem.push_back(fixed ? DW'(k + 1) : DW'($urandom));
        build_expected(x, l);
        pulse_start(x, l);
        drive_src(n, mode, (mode == 2) && (n >= 6));
        wait_trainer_start(name, seen);
        if (seen && a5) begin
            bus.H_OUT_ENABLE  = 1'b1;
            bus.H_OUT         = DW'(8'hA5);
            bus.TRAINER_READY = 1'b1;
            exp_snk_q.push_back(DW'(8'hA5));
            @(negedge CLK);
            bus.H_OUT_ENABLE  = 1'b0;
            bus.TRAINER_READY = 1'b0;
            n_checks++;
            if (bus.SNK_VALID !== 1'b1 || bus.SNK_DATA !== DW'(8'hA5) || bus.CMD_DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_snk_next: valid=%b data=%h done=%b, required 1 a5 0",
                         name, bus.SNK_VALID, bus.SNK_DATA, bus.CMD_DONE);
            end
            @(negedge CLK);
            n_checks++;
            if (bus.CMD_DONE !== 1'b1 || bus.SNK_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_done_after: done=%b snk_valid=%b, required 1 0",
                         name, bus.CMD_DONE, bus.SNK_VALID);
            end
        end else if (seen) begin
            int nh = $urandom_range(0, 3);
            for (int h = 0; h < nh; h++) begin
                bus.H_OUT_ENABLE = 1'b1;
                bus.H_OUT        = DW'($urandom);
                exp_snk_q.push_back(bus.H_OUT);
                @(negedge CLK);
                bus.H_OUT_ENABLE = 1'b0;
                if ($urandom_range(0, 1) == 1) @(negedge CLK);
            end
            bus.TRAINER_READY = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                bus.H_OUT_ENABLE = 1'b1;
                bus.H_OUT        = DW'($urandom);
                exp_snk_q.push_back(bus.H_OUT);
            end
            @(negedge CLK);
            bus.TRAINER_READY = 1'b0;
            bus.H_OUT_ENABLE  = 1'b0;
            wait_cmd_done(name);
        end
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        n_checks++;
        if (act_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_operand_count: got %0d, required %0d", name, act_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (act_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL %s_operand[%0d]: got %h, required %h", name, k, act_q[k], exp_q[k]);
                end
            end
        end
        n_checks++;
        if (ts_cnt !== 1 || ts_cyc <= last_en_cyc) begin
            n_fail++;
            $display("FAIL %s_trainer_start_once: count=%0d at %0d last_enable %0d, required 1 after",
                     name, ts_cnt, ts_cyc, last_en_cyc);
        end
        n_checks++;
        if (act_snk_q.size() !== exp_snk_q.size()) begin
            n_fail++;
            $display("FAIL %s_snk_count: got %0d, required %0d", name, act_snk_q.size(), exp_snk_q.size());
        end else begin
            for (int k = 0; k < exp_snk_q.size(); k++) begin
                n_checks++;
                if (act_snk_q[k] !== exp_snk_q[k]) begin
                    n_fail++;
                    $display("FAIL %s_snk[%0d]: got %h, required %h", name, k, act_snk_q[k], exp_snk_q[k]);
                end
            end
        end
        n_checks++;
        if (done_cnt !== 1 || bus.CMD_BUSY !== 1'b0 || bus.SIZE_ERR !== 1'b0 || bus.TIMEOUT_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end_status: done=%0d busy=%b size_err=%b timeout_err=%b, required 1 0 0 0",
                     name, done_cnt, bus.CMD_BUSY, bus.SIZE_ERR, bus.TIMEOUT_ERR);
        end
    endtask

    task automatic test_size_err(input int x, input int l);
        bit rdy_seen = 1'b0;
        clear_monitor();
        pulse_start(x, l);
        for (int k = 0; k < 6; k++) begin
            if (bus.SRC_READY) rdy_seen = 1'b1;
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.SIZE_ERR !== 1'b1 || done_cnt !== 1 || ts_cnt !== 0 || rdy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL size_err_x%0d_l%0d: err=%b done=%0d start=%0d ready_seen=%b, required 1 1 0 0",
                     x, l, bus.SIZE_ERR, done_cnt, ts_cnt, rdy_seen);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_monitor();
        src_mem.delete();
        for (int k = 0; k < 11; k++) src_mem.push_back(DW'($urandom_range(1, 1000)));
        pulse_start(2, 3);
        drive_src(7, 0, 1'b0);
        n_checks++;
        if (bus.B_IN_ENABLE !== 1'b1 || bus.CMD_BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_in_load_b: b_en=%b busy=%b, required 1 1", bus.B_IN_ENABLE, bus.CMD_BUSY);
        end
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if (outs !== '0 || state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: outs=%h state=%0d, required all 0", outs, state_dbg);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        int gap = 0;
        clear_monitor();
        src_mem.delete();
        for (int k = 0; k < 5; k++) src_mem.push_back(DW'($urandom));
        pulse_start(1, 2);
        drive_src(5, 0, 1'b0);
        wait_trainer_start("timeout", seen);
        if (seen) begin
            while (!bus.CMD_DONE && gap < 100) begin
                @(negedge CLK);
                gap++;
            end
            n_checks++;
            if (gap !== WD || bus.TIMEOUT_ERR !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_watchdog: done after %0d cycles err=%b, required %0d 1",
                         gap, bus.TIMEOUT_ERR, WD);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        run_and_check("const_valid", 2, 3, 0, 1'b1, 1'b0);
        run_and_check("toggle_valid", 2, 3, 1, 1'b1, 1'b0);
        run_and_check("ready_same_cycle", 2, 3, 0, 1'b1, 1'b1);
        test_size_err(0, 3);
        test_size_err(4, 0);
        for (int r = 0; r < 6; r++)
            run_and_check("random", $urandom_range(1, 4), $urandom_range(1, 4), 2, 1'b0, 1'b0);
        run_and_check("edge_1x1", 1, 1, 2, 1'b0, 1'b0);
        test_reset_mid_run();
        run_and_check("after_reset", 2, 3, 0, 1'b0, 1'b0);
`ifdef TRAINER_FNN_SEQUENCER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
